i2c_master_fsm: RTL and testbench
=================================

// Module: i2c_master_fsm
// PURPOSE
//  Single-master I2C bus controller, upstream of the bus slave FSM. Accepts one
//  command (7-bit address, R/W, one data byte), generates SCL from the system
//  clock, drives START, the address byte, one data byte, ACK/NACK and STOP on
//  SDA/SCL, and returns read data plus an ACK status. Its bus pins feed the
//  slave FSM's sda_in/scl_in. The slave's sda_out/sda_select combine with this
//  block's SDA drive in the bus model.
// PARAMETERS
//  CLK_DIV  4  clk cycles per quarter SCL period; legal range >= 2
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  rst_         in   1  reset, synchronous, active-high (1 = reset)
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  1 only in IDLE; handshake = cmd_valid & cmd_ready
//  cmd_addr     in   7  target slave address
//  cmd_rw       in   1  1 = read from slave, 0 = write to slave
//  cmd_wdata    in   8  byte to write (ignored for reads)
//  sda_in       in   1  resolved SDA line value
//  scl_out      out  1  SCL drive (master-only, no clock stretching)
//  sda_out      out  1  SDA value when driven
//  sda_select   out  1  1 = master drives SDA, 0 = SDA released (slave drives)
//  rdata        out  8  received byte, valid while done=1 and cmd_rw was 1
//  nack         out  1  1 = an expected ACK was missing; valid with done
//  done         out  1  one-cycle pulse at end of transaction
//  busy         out  1  1 from accept until done
// BEHAVIOUR
//  - Reset: state=IDLE; scl_out=1, sda_out=1, sda_select=1; cmd_ready=1 on the
//    first cycle after reset deasserts; rdata=0, nack=0, done=0, busy=0.
//  - Reset mid-transfer: immediate return to reset values. No STOP is issued.
//    The slave resynchronises on the next START.
//  - Accept: in IDLE, cmd_valid & cmd_ready latches addr/rw/wdata. busy=1 next cycle.
//  - Timing: quarter tick every CLK_DIV clks. Each bit = 4 phases P0..P3.
//    P0,P1: SCL=0. P2,P3: SCL=1. SDA changes only at P0 entry.
//    sda_in is sampled on the tick ending P2.
//  - Bit order: MSB first. Address byte = {cmd_addr, cmd_rw}.
//  - States and transitions:
//    IDLE -> START on accept.
//    START: P0 SCL1/SDA1, P1 SCL1/SDA0, P2 SCL1/SDA0, P3 SCL0/SDA0 -> ADDR.
//    ADDR: 8 bits driven -> ADDR_ACK.
//    ADDR_ACK: SDA released. Sample 0 -> WR_DATA (rw=0) or RD_DATA (rw=1).
//      Sample 1 -> nack=1 -> STOP.
//    WR_DATA: 8 bits driven -> WR_ACK. WR_ACK: released; sample 1 sets nack -> STOP.
//    RD_DATA: released, 8 samples shifted into rdata -> RD_NACK.
//    RD_NACK: drive SDA=1, single-byte read ends -> STOP.
//    STOP: P0 SCL0/SDA0, P1 SCL1/SDA0, P2 SCL1/SDA1, P3 SCL1/SDA1 -> IDLE.
//      done=1 for the one cycle of the IDLE transition; busy=0 on that cycle.
//  - Latency (accept to done), ACKed: 4*CLK_DIV*(1+9+9+1) = 80*CLK_DIV clks
//    (+1 accept cycle). Address NACK: 44*CLK_DIV.
//  - 3-bit bit counter counts 7 down to 0 and wraps to 7 when leaving a byte.
//    The divider counter restarts at 0 on accept.
//  - cmd_valid while busy: ignored, no queuing. cmd_* may change after accept.
//  - sda_select=0 only in ADDR_ACK, WR_ACK and RD_DATA. It is 1 everywhere else.
//  - Outputs are registered. No combinational path from sda_in to any output.
// STRUCTURE
//  - Shared package i2c_pkg: state localparams (4-bit), phase encodings,
//    I2C_RW_READ/WRITE constants, default slave address 7'b1011010 for benches.
//  - Sub-module i2c_quarter_tick: CLK_DIV counter, emits tick and the 2-bit phase.
//    Cleared by rst_ and by accept.
// TESTING
//  1 Reset: rst_=1 for 3 clks mid-ADDR -> next cycle scl_out=1, sda_out=1,
//    sda_select=1, busy=0, cmd_ready=1.
//  2 Write, slave ACKs: addr=7'h5A, rw=0, wdata=8'hA5, CLK_DIV=4.
//    -> SDA bits 1011_0100, then 1010_0101, STOP; done at 320+1 clks, nack=0.
//  3 Read: addr=7'h5A, rw=1, slave model returns 8'h3C.
//    -> rdata=8'h3C with done, master drives NACK (SDA=1) on 9th bit, nack=0.
//  4 Address NACK: no slave ACK (sda_in=1).
//    -> nack=1, no data phase, STOP follows ADDR_ACK, done at 176+1 clks.
//  5 Busy guard: second cmd_valid 10 clks after accept -> cmd_ready=0, ignored.
//    The first transaction completes unchanged.
//  6 Bus check: assert that SDA toggles with SCL=1 only in START P1 and STOP P2,
//    across random addr/data/rw, CLK_DIV in {2,4,7}.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants for the single-master I2C controller: FSM state codes,
// quarter-bit phase codes, R/W bit values and a default slave address.
package i2c_pkg;

    // Controller states (4-bit encoding)
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_START    = 4'd1;
    localparam logic [3:0] ST_ADDR     = 4'd2;
    localparam logic [3:0] ST_ADDR_ACK = 4'd3;
    localparam logic [3:0] ST_WR_DATA  = 4'd4;
    localparam logic [3:0] ST_WR_ACK   = 4'd5;
    localparam logic [3:0] ST_RD_DATA  = 4'd6;
    localparam logic [3:0] ST_RD_NACK  = 4'd7;
    localparam logic [3:0] ST_STOP     = 4'd8;

    // Quarter-bit phases: P0/P1 have SCL low, P2/P3 have SCL high
    localparam logic [1:0] PH_P0 = 2'd0;
    localparam logic [1:0] PH_P1 = 2'd1;
    localparam logic [1:0] PH_P2 = 2'd2;
    localparam logic [1:0] PH_P3 = 2'd3;

    // Value of the R/W bit in the address byte
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // Default slave address used by benches
    localparam logic [6:0] I2C_DEFAULT_SLAVE_ADDR = 7'b1011010;

    // SCL level for an ordinary data/ack bit in a given phase
    function automatic logic phase_scl(input logic [1:0] ph);
        return ph[1];
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: a CLK_DIV clock divider producing a one-cycle tick
// and a 2-bit phase counter that advances on every tick. Both counters are
// cleared when a new command is accepted so every transfer starts aligned.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       clear,
    output logic       tick,
    output logic [1:0] phase,
    output logic [1:0] phase_next
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;
    logic [1:0]    phase_q;
    logic [1:0]    phase_d;

    assign tick       = (div_q == DIV_LAST);
    assign phase      = phase_q;
    assign phase_next = phase_d;

    // Next divider/phase values; a clear overrides the free-running count
    always_comb begin
        div_d   = tick ? '0 : div_q + CW'(1);
        phase_d = tick ? phase_q + 2'd1 : phase_q;
        if (clear) begin
            div_d   = '0;
            phase_d = PH_P0;
        end
    end

    // Divider and phase registers
    always_ff @(posedge clk) begin
        if (rst_) begin
            div_q   <= '0;
            phase_q <= PH_P0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_master_fsm.sv
// Single-master I2C controller: one command = START, address byte, one data
// byte (write or read), ACK/NACK, STOP. SCL is generated from the system clock
// with four CLK_DIV-long phases per bit. All bus pins and status outputs are
// registered; their next values are decoded from the next state/phase so the
// pins change cleanly on a single edge.
module i2c_master_fsm
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       sda_select,
    output logic [7:0] rdata,
    output logic       nack,
    output logic       done,
    output logic       busy
);

    logic [3:0] state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] addr_byte_q, addr_byte_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       sel_q, sel_d;

    logic       accept;
    logic       tick;
    logic [1:0] phase;
    logic [1:0] phase_next;
    logic       bit_end;
    logic       sample;

    assign accept  = cmd_valid & ready_q;
    assign bit_end = tick & (phase == PH_P3);
    assign sample  = tick & (phase == PH_P2);

    i2c_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_      (rst_),
        .clear     (accept),
        .tick      (tick),
        .phase     (phase),
        .phase_next(phase_next)
    );

    // Transaction sequencing: state, bit counter, captured command, read data, ack status
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        addr_byte_d = addr_byte_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_START;
                    addr_byte_d = {cmd_addr, cmd_rw};
                    wdata_d     = cmd_wdata;
                    rw_d        = cmd_rw;
                    rdata_d     = '0;
                    nack_d      = 1'b0;
                    bit_d       = 3'd7;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                // Counter wraps 0 -> 7 on the last bit, ready for the next byte
                if (bit_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = ST_ADDR_ACK;
                end
            end
            ST_ADDR_ACK: begin
                if (sample && sda_in) nack_d = 1'b1;
                if (bit_end) begin
                    if (nack_q)                    state_d = ST_STOP;
                    else if (rw_q == I2C_RW_READ)  state_d = ST_RD_DATA;
                    else                           state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (bit_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = ST_WR_ACK;
                end
            end
            ST_WR_ACK: begin
                if (sample && sda_in) nack_d = 1'b1;
                if (bit_end) state_d = ST_STOP;
            end
            ST_RD_DATA: begin
                if (sample) rdata_d = {rdata_q[6:0], sda_in};
                if (bit_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = ST_RD_NACK;
                end
            end
            ST_RD_NACK: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus pin and handshake decode from the upcoming state/phase/bit
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        sel_d = 1'b1;
        case (state_d)
            ST_START: begin
                // SDA falls while SCL high (P1), SCL drops in P3
                scl_d = (phase_next != PH_P3);
                sda_d = (phase_next == PH_P0);
            end
            ST_ADDR: begin
                scl_d = phase_scl(phase_next);
                sda_d = addr_byte_q[bit_d];
            end
            ST_ADDR_ACK, ST_WR_ACK, ST_RD_DATA: begin
                scl_d = phase_scl(phase_next);
                sel_d = 1'b0;
            end
            ST_WR_DATA: begin
                scl_d = phase_scl(phase_next);
                sda_d = wdata_q[bit_d];
            end
            ST_RD_NACK: begin
                scl_d = phase_scl(phase_next);
            end
            ST_STOP: begin
                // SCL rises in P1, SDA rises while SCL high in P2
                scl_d = (phase_next != PH_P0);
                sda_d = (phase_next == PH_P2) || (phase_next == PH_P3);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
                sel_d = 1'b1;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q     <= ST_IDLE;
            bit_q       <= 3'd7;
            addr_byte_q <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            rdata_q     <= '0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            sel_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            addr_byte_q <= addr_byte_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            sel_q       <= sel_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign scl_out    = scl_q;
    assign sda_out    = sda_q;
    assign sda_select = sel_q;
    assign rdata      = rdata_q;
    assign nack       = nack_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Bench for i2c_master_fsm: three instances (CLK_DIV 4, 2, 7) share the command
// inputs; each has its own behavioural slave that decodes the bus by counting
// SCL edges since START. Expectations come from bus-level rules: bit layout,
// transfer length in phases, START/STOP position.
module tb_i2c_master_fsm;
    import i2c_pkg::*;

    localparam int NI   = 3;
    localparam int MAXK = 80 * 7 + 4;

    function automatic int div_of(input int i);
        if (i == 0) return 4;
        if (i == 1) return 2;
        return 7;
    endfunction

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_        = 1'b1;
    logic       cmd_valid   = 1'b0;
    logic [6:0] cmd_addr    = '0;
    logic       cmd_rw      = 1'b0;
    logic [7:0] cmd_wdata   = '0;
    logic       addr_ack_en = 1'b1;
    logic       data_ack_en = 1'b1;
    logic [7:0] slave_rbyte = '0;

    logic        cmd_ready_w [NI];
    logic        scl_w       [NI];
    logic        sda_out_w   [NI];
    logic        sel_w       [NI];
    logic        nack_w      [NI];
    logic        done_w      [NI];
    logic        busy_w      [NI];
    logic        sda_line    [NI];
    logic [7:0]  rdata_w     [NI];
    logic [19:0] cap_w       [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Slave drive for bit index b (1..8 addr, 9 ack, 10..17 data, 18 ack/nack)
    function automatic logic slave_val(input int b, input logic [19:0] c, input logic aack,
                                       input logic dack, input logic [7:0] rb);
        logic [7:0] rbv;
        rbv = rb;
        if (b == 9) return ~aack;
        if (c[8] == I2C_RW_WRITE && b == 18) return ~dack;
        if (c[8] == I2C_RW_READ && aack && b >= 10 && b <= 17) return rbv[3'(17 - b)];
        return 1'b1;
    endfunction

    function automatic logic [7:0] byte_at(input logic [19:0] c, input int first);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r = {r[6:0], c[5'(first + j)]};
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            logic        sda_in_l;
            logic        slave_v;
            logic        pscl = 1'b1;
            logic        psda = 1'b1;
            int          b    = 0;
            logic [19:0] capv = '0;

            i2c_master_fsm #(
                .CLK_DIV(div_of(gi))
            ) u_dut (
                .clk       (clk),
                .rst_      (rst_),
                .cmd_valid (cmd_valid),
                .cmd_ready (cmd_ready_w[gi]),
                .cmd_addr  (cmd_addr),
                .cmd_rw    (cmd_rw),
                .cmd_wdata (cmd_wdata),
                .sda_in    (sda_in_l),
                .scl_out   (scl_w[gi]),
                .sda_out   (sda_out_w[gi]),
                .sda_select(sel_w[gi]),
                .rdata     (rdata_w[gi]),
                .nack      (nack_w[gi]),
                .done      (done_w[gi]),
                .busy      (busy_w[gi])
            );

            always_comb slave_v = slave_val(b, capv, addr_ack_en, data_ack_en, slave_rbyte);
            assign sda_in_l     = sel_w[gi] ? sda_out_w[gi] : slave_v;
            assign sda_line[gi] = sda_in_l;
            assign cap_w[gi]    = capv;

            // Slave bus decoder: START resets the bit index, SCL fall advances it, SCL rise captures
            always @(negedge clk) begin
                pscl <= scl_w[gi];
                psda <= sda_in_l;
                if (pscl && scl_w[gi] && psda && !sda_in_l) begin
                    b    <= 0;
                    capv <= '0;
                end else if (pscl && !scl_w[gi]) begin
                    b <= b + 1;
                end else if (!pscl && scl_w[gi] && b >= 0 && b < 20) begin
                    capv[5'(b)] <= sda_in_l;
                end
            end
        end
    endgenerate

    task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd);
        @(negedge clk);
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 7'($urandom);
        cmd_rw    = 1'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic run_txn(input string tag, input logic [6:0] a, input logic rw,
                           input logic [7:0] wd, input logic aack, input logic dack,
                           input logic [7:0] rb, input bit guard);
        int         done_k [NI];
        int         start_k[NI];
        int         stop_k [NI];
        int         n_start[NI];
        int         n_stop [NI];
        logic       got_nack [NI];
        logic       got_busy [NI];
        logic       got_ready[NI];
        logic       after_done[NI];
        logic [7:0] got_rdata[NI];
        logic       ps[NI];
        logic       pd[NI];
        int         d;
        int         exp_len;
        logic       exp_nack;

        addr_ack_en = aack;
        data_ack_en = dack;
        slave_rbyte = rb;
        issue(a, rw, wd);
        for (int i = 0; i < NI; i++) begin
            done_k[i] = -1; start_k[i] = -1; stop_k[i] = -1;
            n_start[i] = 0; n_stop[i] = 0;
            got_nack[i] = 1'bx; got_busy[i] = 1'bx; got_ready[i] = 1'bx;
            after_done[i] = 1'bx; got_rdata[i] = 'x;
            ps[i] = scl_w[i];
            pd[i] = sda_line[i];
            n_checks++;
            if (busy_w[i] !== 1'b1 || cmd_ready_w[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d accept: busy=%b ready=%b, required busy=1 ready=0",
                         tag, i, busy_w[i], cmd_ready_w[i]);
            end
        end

        for (int k = 1; k <= MAXK; k++) begin
            @(negedge clk);
            if (guard && k == 10) begin
                for (int i = 0; i < NI; i++) begin
                    n_checks++;
                    if (cmd_ready_w[i] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s dut%0d busy_ready: ready=%b, required 0", tag, i, cmd_ready_w[i]);
                    end
                end
                cmd_addr  = ~a;
                cmd_rw    = ~rw;
                cmd_wdata = ~wd;
                cmd_valid = 1'b1;
            end else if (guard && k == 11) begin
                cmd_valid = 1'b0;
            end
            for (int i = 0; i < NI; i++) begin
                if (ps[i] && scl_w[i] && (pd[i] !== sda_line[i])) begin
                    if (sda_line[i] === 1'b0) begin
                        n_start[i]++;
                        start_k[i] = k;
                    end else begin
                        n_stop[i]++;
                        stop_k[i] = k;
                    end
                end
                if (done_k[i] >= 0 && k == done_k[i] + 1) after_done[i] = done_w[i];
                if (done_w[i] === 1'b1 && done_k[i] < 0) begin
                    done_k[i]    = k;
                    got_nack[i]  = nack_w[i];
                    got_rdata[i] = rdata_w[i];
                    got_busy[i]  = busy_w[i];
                    got_ready[i] = cmd_ready_w[i];
                end
                ps[i] = scl_w[i];
                pd[i] = sda_line[i];
            end
        end

        for (int i = 0; i < NI; i++) begin
            d        = div_of(i);
            exp_len  = aack ? 80 * d : 44 * d;
            exp_nack = !aack || (rw == I2C_RW_WRITE && !dack);

            n_checks++;
            if (done_k[i] != exp_len) begin
                n_fail++;
                $display("FAIL %s dut%0d latency: done after %0d clks, required %0d", tag, i, done_k[i], exp_len);
            end
            n_checks++;
            if (got_nack[i] !== exp_nack) begin
                n_fail++;
                $display("FAIL %s dut%0d nack: got %b, required %b", tag, i, got_nack[i], exp_nack);
            end
            n_checks++;
            if ({got_busy[i], got_ready[i], after_done[i]} !== 3'b010) begin
                n_fail++;
                $display("FAIL %s dut%0d done_cycle: busy,ready,next_done=%b%b%b, required 010",
                         tag, i, got_busy[i], got_ready[i], after_done[i]);
            end
            n_checks++;
            if (byte_at(cap_w[i], 1) !== {a, rw}) begin
                n_fail++;
                $display("FAIL %s dut%0d addr_byte: bus %h, required %h", tag, i, byte_at(cap_w[i], 1), {a, rw});
            end
            if (aack && rw == I2C_RW_WRITE) begin
                n_checks++;
                if (byte_at(cap_w[i], 10) !== wd) begin
                    n_fail++;
                    $display("FAIL %s dut%0d wdata: bus %h, required %h", tag, i, byte_at(cap_w[i], 10), wd);
                end
            end
            if (aack && rw == I2C_RW_READ) begin
                n_checks++;
                if (got_rdata[i] !== rb) begin
                    n_fail++;
                    $display("FAIL %s dut%0d rdata: got %h, required %h", tag, i, got_rdata[i], rb);
                end
                n_checks++;
                if (cap_w[i][18] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s dut%0d master_nack: bit9 SDA=%b, required 1", tag, i, cap_w[i][18]);
                end
            end
            n_checks++;
            if (n_start[i] != 1 || n_stop[i] != 1 || start_k[i] != d || stop_k[i] != exp_len - 2 * d) begin
                n_fail++;
                $display("FAIL %s dut%0d bus_sda_scl_high: starts=%0d@%0d stops=%0d@%0d, required 1@%0d 1@%0d",
                         tag, i, n_start[i], start_k[i], n_stop[i], stop_k[i], d, exp_len - 2 * d);
            end
            n_checks++;
            if (busy_w[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d idle_after: busy=%b, required 0", tag, i, busy_w[i]);
            end
        end
        $display("txn %s addr=%h rw=%b wdata=%h aack=%b dack=%b slave_byte=%h checked", tag, a, rw, wd, aack, dack, rb);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if ({scl_w[i], sda_out_w[i], sel_w[i], busy_w[i], cmd_ready_w[i], done_w[i], nack_w[i]} !== 7'b1110100) begin
                n_fail++;
                $display("FAIL %s dut%0d pins: scl,sda,sel,busy,ready,done,nack=%b%b%b%b%b%b%b, required 1110100",
                         tag, i, scl_w[i], sda_out_w[i], sel_w[i], busy_w[i], cmd_ready_w[i], done_w[i], nack_w[i]);
            end
            n_checks++;
            if (rdata_w[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL %s dut%0d rdata: got %h, required 00", tag, i, rdata_w[i]);
            end
        end
        $display("txn %s reset state checked", tag);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        check_reset_state("power_up");
        issue(I2C_DEFAULT_SLAVE_ADDR, I2C_RW_WRITE, 8'hA5);
        repeat (40) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (busy_w[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_addr dut%0d busy: got %b, required 1", i, busy_w[i]);
            end
        end
        rst_ = 1'b1;
        repeat (3) @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        check_reset_state("reset_mid_addr");
    endtask

    task automatic test_write();
        run_txn("write", I2C_DEFAULT_SLAVE_ADDR, I2C_RW_WRITE, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_read();
        run_txn("read", I2C_DEFAULT_SLAVE_ADDR, I2C_RW_READ, 8'($urandom), 1'b1, 1'b1, 8'h3C, 1'b0);
    endtask

    task automatic test_addr_nack();
        run_txn("addr_nack_wr", I2C_DEFAULT_SLAVE_ADDR, I2C_RW_WRITE, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);
        run_txn("addr_nack_rd", 7'h11, I2C_RW_READ, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
    endtask

    task automatic test_data_nack();
        run_txn("data_nack", 7'h2B, I2C_RW_WRITE, 8'h81, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_busy_guard();
        run_txn("busy_guard", I2C_DEFAULT_SLAVE_ADDR, I2C_RW_WRITE, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic test_random_bus();
        for (int n = 0; n < 8; n++) begin
            run_txn("random", 7'($urandom), 1'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_busy_guard();
        test_random_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
